// File: rtl/shifter_pkg.sv
// Shared types for the execute-stage shifter operand unit.
package shifter_pkg;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } sh_type_t;

   typedef enum logic {
      S_RUN = 1'b0,
      S_RS  = 1'b1
   } sh_state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational ARM barrel shifter: immediate-amount and register-amount
// encodings, including the amount 0 / 32 / >32 special cases.
module shift_core
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] opnd,
   input  sh_type_t         sh_type,
   input  logic [7:0]       amt,
   input  logic             is_reg,
   input  logic             cin,
   output logic [WIDTH-1:0] res,
   output logic             cout
);

   logic [4:0]         n5;
   logic [4:0]         idx_l;
   logic [4:0]         idx_r;
   logic               zero5;
   logic               lt32;
   logic               eq32;
   logic [WIDTH-1:0]   shl;
   logic [WIDTH-1:0]   shr;
   logic [WIDTH-1:0]   sar;
   logic [WIDTH-1:0]   ror;
   logic [2*WIDTH-1:0] ror_w;

   assign n5    = amt[4:0];
   assign zero5 = (n5 == 5'd0);
   assign lt32  = (amt[7:5] == 3'd0);
   assign eq32  = (amt == 8'd32);

   // Carry bit indices stay 5 bits wide; they are only used when n5 is 1..31.
   assign idx_l = 5'(6'd32 - {1'b0, n5});
   assign idx_r = n5 - 5'd1;

   assign shl   = opnd << n5;
   assign shr   = opnd >> n5;
   assign sar   = $unsigned($signed(opnd) >>> n5);
   assign ror_w = {opnd, opnd} >> n5;
   assign ror   = ror_w[WIDTH-1:0];

   always_comb begin
      res  = opnd;
      cout = cin;
      if (!is_reg) begin
         unique case (sh_type)
            SH_LSL: if (!zero5) begin res = shl; cout = opnd[idx_l]; end
            SH_LSR: if (zero5) begin res = '0; cout = opnd[WIDTH-1]; end
                    else begin res = shr; cout = opnd[idx_r]; end
            SH_ASR: if (zero5) begin res = {WIDTH{opnd[WIDTH-1]}}; cout = opnd[WIDTH-1]; end
                    else begin res = sar; cout = opnd[idx_r]; end
            SH_ROR: if (zero5) begin res = {cin, opnd[WIDTH-1:1]}; cout = opnd[0]; end
                    else begin res = ror; cout = opnd[idx_r]; end
            default: ;
         endcase
      end else if (amt != 8'd0) begin
         // amt != 0 together with lt32 guarantees n5 is 1..31.
         unique case (sh_type)
            SH_LSL: if (lt32) begin res = shl; cout = opnd[idx_l]; end
                    else if (eq32) begin res = '0; cout = opnd[0]; end
                    else begin res = '0; cout = 1'b0; end
            SH_LSR: if (lt32) begin res = shr; cout = opnd[idx_r]; end
                    else if (eq32) begin res = '0; cout = opnd[WIDTH-1]; end
                    else begin res = '0; cout = 1'b0; end
            SH_ASR: if (lt32) begin res = sar; cout = opnd[idx_r]; end
                    else begin res = {WIDTH{opnd[WIDTH-1]}}; cout = opnd[WIDTH-1]; end
            SH_ROR: if (zero5) begin res = opnd; cout = opnd[WIDTH-1]; end
                    else begin res = ror; cout = opnd[idx_r]; end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/shifter_ex.sv
// Execute-stage shifter operand: 1-cycle immediate paths, 2-cycle
// register-specified shifts with a one-cycle decode hold request.
module shifter_ex
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ValidD,
   input  logic             ImmOpD,
   input  logic [WIDTH-1:0] RotImmD,
   input  logic             RotNzD,
   input  logic [WIDTH-1:0] RegBD,
   input  logic [1:0]       ShTypeD,
   input  logic [4:0]       ShImmD,
   input  logic             RegShD,
   input  logic [7:0]       RsByteD,
   input  logic             CFlagE,
   input  logic             StallE,
   input  logic             FlushE,
   output logic             StallReqD,
   output logic [WIDTH-1:0] ShOpE,
   output logic             ShCarryE,
   output logic             ValidE
);

   sh_state_t        state, state_d;
   logic [WIDTH-1:0] rm_q;
   sh_type_t         type_q;
   logic             accept;
   logic             reg_acc;
   logic [WIDTH-1:0] core_opnd;
   sh_type_t         core_type;
   logic [7:0]       core_amt;
   logic             core_isreg;
   logic [WIDTH-1:0] core_res;
   logic             core_cout;

   assign accept  = (state == S_RUN) & ValidD & ~StallE & ~FlushE;
   assign reg_acc = accept & ~ImmOpD & RegShD;

   // One shifter serves both paths; S_RS replays the latched Rm with the Rs byte.
   always_comb begin
      core_opnd  = RegBD;
      core_type  = sh_type_t'(ShTypeD);
      core_amt   = {3'b000, ShImmD};
      core_isreg = 1'b0;
      if (state == S_RS) begin
         core_opnd  = rm_q;
         core_type  = type_q;
         core_amt   = RsByteD;
         core_isreg = 1'b1;
      end
   end

   shift_core #(.WIDTH(WIDTH)) u_core (
      .opnd    (core_opnd),
      .sh_type (core_type),
      .amt     (core_amt),
      .is_reg  (core_isreg),
      .cin     (CFlagE),
      .res     (core_res),
      .cout    (core_cout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_RUN;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (FlushE) state_d = S_RUN;
      else if (!StallE) begin
         unique case (state)
            S_RUN:   if (reg_acc) state_d = S_RS;
            S_RS:    state_d = S_RUN;
            default: state_d = S_RUN;
         endcase
      end
   end

   always_comb begin
      StallReqD = reset_n & reg_acc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ShOpE    <= '0;
         ShCarryE <= 1'b0;
         ValidE   <= 1'b0;
         rm_q     <= '0;
         type_q   <= SH_LSL;
      end else if (FlushE) begin
         ValidE <= 1'b0;
      end else if (!StallE) begin
         if (state == S_RS) begin
            ShOpE    <= core_res;
            ShCarryE <= core_cout;
            ValidE   <= 1'b1;
         end else if (accept && ImmOpD) begin
            ShOpE    <= RotImmD;
            ShCarryE <= RotNzD ? RotImmD[WIDTH-1] : CFlagE;
            ValidE   <= 1'b1;
         end else if (accept && !RegShD) begin
            ShOpE    <= core_res;
            ShCarryE <= core_cout;
            ValidE   <= 1'b1;
         end else if (reg_acc) begin
            rm_q   <= RegBD;
            type_q <= sh_type_t'(ShTypeD);
            ValidE <= 1'b0;
         end else begin
            ValidE <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shifter_ex.sv
// Scoreboard bench for shifter_ex: expected {ShOpE,ShCarryE} pushed at drive time.
module tb_shifter_ex;
   import shifter_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ValidD, ImmOpD, RotNzD, RegShD, CFlagE, StallE, FlushE;
   logic [31:0] RotImmD, RegBD;
   logic [1:0]  ShTypeD;
   logic [4:0]  ShImmD;
   logic [7:0]  RsByteD;
   logic        StallReqD, ShCarryE, ValidE;
   logic [31:0] ShOpE;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [32:0] sb[$];
   logic [32:0] got, e;

   always #5 clk = ~clk;

   shifter_ex dut (
      .clk(clk), .reset_n(reset_n), .ValidD(ValidD), .ImmOpD(ImmOpD),
      .RotImmD(RotImmD), .RotNzD(RotNzD), .RegBD(RegBD), .ShTypeD(ShTypeD),
      .ShImmD(ShImmD), .RegShD(RegShD), .RsByteD(RsByteD), .CFlagE(CFlagE),
      .StallE(StallE), .FlushE(FlushE), .StallReqD(StallReqD), .ShOpE(ShOpE),
      .ShCarryE(ShCarryE), .ValidE(ValidE)
   );

   // Reference: shift a widened word so the carry falls out of the extra bit.
   function automatic logic [32:0] model_reg(input logic [31:0] rm, input logic [1:0] t,
                                             input logic [7:0] s, input logic cf);
      logic [64:0]        wl;
      logic [32:0]        wr;
      logic signed [32:0] ws;
      logic [31:0]        r;
      int                 k;
      if (s == 8'd0) return {rm, cf};
      case (t)
         2'd0: begin wl = {33'b0, rm} << s; return {wl[31:0], wl[32]}; end
         2'd1: begin wr = {rm, 1'b0} >> s; return {wr[32:1], wr[0]}; end
         2'd2: begin ws = $signed({rm, 1'b0}) >>> s; return {ws[32:1], ws[0]}; end
         default: begin
            k = int'(s) % 32;
            if (k == 0) return {rm, rm[31]};
            r = (rm >> k) | (rm << (32 - k));
            return {r, r[31]};
         end
      endcase
   endfunction

   function automatic logic [32:0] model_imm(input logic [31:0] rm, input logic [1:0] t,
                                             input logic [4:0] n, input logic cf);
      if (n != 5'd0) return model_reg(rm, t, {3'b000, n}, cf);
      case (t)
         2'd0:    return {rm, cf};
         2'd3:    return {cf, rm[31:1], rm[0]};
         default: return model_reg(rm, t, 8'd32, cf);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ValidD = 0; ImmOpD = 0; RotNzD = 0; RegShD = 0; RotImmD = '0; RegBD = '0;
      ShTypeD = '0; ShImmD = '0; RsByteD = '0; CFlagE = 0; StallE = 0; FlushE = 0;
   endtask

   task automatic drive_imm(input logic [31:0] imm, input logic nz, input logic cf);
      ValidD = 1; ImmOpD = 1; RegShD = 0; RotImmD = imm; RotNzD = nz; CFlagE = cf;
      sb.push_back({imm, nz ? imm[31] : cf});
   endtask

   task automatic test_reset();
      idle();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", ValidE); end
      n_chk++; if (ShOpE !== 32'h0) begin n_fail++; $display("FAIL reset_shop got=%h want=0", ShOpE); end
      n_chk++; if (ShCarryE !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b want=0", ShCarryE); end
      @(negedge clk);
      reset_n = 1;
      tick();
   endtask

   task automatic test_imm();
      logic [31:0] imm[3] = '{32'hF000000F, 32'h80000000, 32'h000000FF};
      logic        nz[3]  = '{1'b1, 1'b0, 1'b0};
      logic        cf[3]  = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive_imm(imm[i], nz[i], cf[i]);
         #1;
         n_chk++; if (StallReqD !== 1'b0) begin n_fail++; $display("FAIL imm_stallreq got=%b want=0", StallReqD); end
         tick();
         idle();
         n_chk++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL imm_valid got=%b want=1", ValidE); end
         got = {ShOpE, ShCarryE};
         n_chk++;
         if (sb.size() == 0) begin n_fail++; $display("FAIL imm_sb_empty got=%h", got); end
         else begin
            e = sb.pop_front();
            if (got !== e) begin n_fail++; $display("FAIL imm_result got=%h want=%h", got, e); end
         end
      end
   endtask

   task automatic test_imm_shift();
      logic [1:0]  ft[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      logic [4:0]  fn[4] = '{5'd0, 5'd0, 5'd0, 5'd1};
      logic [32:0] fe[4] = '{{32'h00000000, 1'b1}, {32'hFFFFFFFF, 1'b1},
                             {32'h40000000, 1'b1}, {32'h00000002, 1'b1}};
      logic [31:0] rm;
      logic [1:0]  t;
      logic [4:0]  n;
      logic        cf;
      for (int i = 0; i < 16; i++) begin
         if (i < 4) begin
            rm = 32'h80000001; t = ft[i]; n = fn[i]; cf = 1'b0; e = fe[i];
         end else begin
            rm = $urandom; t = 2'($urandom_range(0, 3)); cf = 1'($urandom);
            n = (i < 8) ? 5'd0 : 5'($urandom_range(0, 31));
            e = model_imm(rm, t, n, cf);
         end
         ValidD = 1; ImmOpD = 0; RegShD = 0; RegBD = rm; ShTypeD = t; ShImmD = n; CFlagE = cf;
         sb.push_back(e);
         tick();
         idle();
         n_chk++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL ishift_valid i=%0d got=%b want=1", i, ValidE); end
         got = {ShOpE, ShCarryE};
         n_chk++;
         if (sb.size() == 0) begin n_fail++; $display("FAIL ishift_sb_empty got=%h", got); end
         else begin
            e = sb.pop_front();
            if (got !== e) begin n_fail++; $display("FAIL ishift i=%0d t=%0d n=%0d got=%h want=%h", i, t, n, got, e); end
         end
      end
   endtask

   task automatic test_reg_shift();
      logic [31:0] frm[5] = '{32'h1, 32'h1, 32'h1, 32'h12345678, 32'h12345678};
      logic [1:0]  ft[5]  = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
      logic [7:0]  fs[5]  = '{8'h20, 8'h21, 8'h00, 8'h20, 8'h04};
      logic        fcf[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [32:0] fe[5]  = '{{32'h0, 1'b1}, {32'h0, 1'b0}, {32'h1, 1'b1},
                              {32'h12345678, 1'b0}, {32'h81234567, 1'b1}};
      logic [31:0] rm;
      logic [1:0]  t;
      logic [7:0]  s;
      logic        cf;
      for (int i = 0; i < 17; i++) begin
         if (i < 5) begin
            rm = frm[i]; t = ft[i]; s = fs[i]; cf = fcf[i]; e = fe[i];
         end else begin
            rm = $urandom; t = 2'($urandom_range(0, 3)); cf = 1'($urandom);
            s = (i < 11) ? 8'(30 + $urandom_range(0, 4)) : 8'($urandom);
            e = model_reg(rm, t, s, cf);
         end
         ValidD = 1; ImmOpD = 0; RegShD = 1; RegBD = rm; ShTypeD = t; CFlagE = cf;
         #1;
         n_chk++; if (StallReqD !== 1'b1) begin n_fail++; $display("FAIL rshift_stallreq got=%b want=1", StallReqD); end
         tick();
         idle();
         RsByteD = s; CFlagE = cf;
         sb.push_back(e);
         #1;
         n_chk++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL rshift_bubble got=%b want=0", ValidE); end
         n_chk++; if (StallReqD !== 1'b0) begin n_fail++; $display("FAIL rshift_rs_stallreq got=%b want=0", StallReqD); end
         tick();
         idle();
         n_chk++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL rshift_valid got=%b want=1", ValidE); end
         got = {ShOpE, ShCarryE};
         n_chk++;
         if (sb.size() == 0) begin n_fail++; $display("FAIL rshift_sb_empty got=%h", got); end
         else begin
            e = sb.pop_front();
            if (got !== e) begin n_fail++; $display("FAIL rshift i=%0d t=%0d s=%0d got=%h want=%h", i, t, s, got, e); end
         end
      end
   endtask

   task automatic test_stall();
      logic [32:0] held;
      drive_imm(32'h0BADF00D, 1'b0, 1'b1);
      held = {32'h0BADF00D, 1'b1};
      tick();
      idle();
      got = {ShOpE, ShCarryE};
      e = sb.pop_front();
      n_chk++; if (got !== e) begin n_fail++; $display("FAIL stall_pre got=%h want=%h", got, e); end
      ValidD = 1; RegShD = 1; RegBD = 32'h80000000; ShTypeD = 2'd2;
      tick();
      idle();
      RsByteD = 8'd4; CFlagE = 1'b0; StallE = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         got = {ShOpE, ShCarryE};
         n_chk++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL stall_valid c=%0d got=%b want=0", i, ValidE); end
         n_chk++; if (got !== held) begin n_fail++; $display("FAIL stall_hold c=%0d got=%h want=%h", i, got, held); end
         n_chk++; if (StallReqD !== 1'b0) begin n_fail++; $display("FAIL stall_req c=%0d got=%b want=0", i, StallReqD); end
      end
      StallE = 0;
      sb.push_back({32'hF8000000, 1'b0});
      tick();
      idle();
      n_chk++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid got=%b want=1", ValidE); end
      got = {ShOpE, ShCarryE};
      e = sb.pop_front();
      n_chk++; if (got !== e) begin n_fail++; $display("FAIL stall_release got=%h want=%h", got, e); end
   endtask

   task automatic test_back_to_back();
      ValidD = 1; RegShD = 1; RegBD = 32'h3; ShTypeD = 2'd0;
      tick();
      idle();
      RsByteD = 8'd1; FlushE = 1; StallE = 1;
      tick();
      idle();
      n_chk++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b want=0", ValidE); end
      n_chk++; if (dut.state !== S_RUN) begin n_fail++; $display("FAIL flush_state got=%0d want=%0d", dut.state, S_RUN); end
      for (int i = 0; i < 5; i++) begin
         drive_imm($urandom, 1'($urandom), 1'($urandom));
         tick();
         n_chk++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL b2b_valid i=%0d got=%b want=1", i, ValidE); end
         got = {ShOpE, ShCarryE};
         e = sb.pop_front();
         n_chk++; if (got !== e) begin n_fail++; $display("FAIL b2b i=%0d got=%h want=%h", i, got, e); end
      end
      idle();
      tick();
      n_chk++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b want=0", ValidE); end
   endtask

   task automatic test_reset_mid_rs();
      drive_imm(32'hA5A5A5A5, 1'b1, 1'b0);
      tick();
      idle();
      sb.delete();
      ValidD = 1; RegShD = 1; RegBD = 32'h1; ShTypeD = 2'd0;
      tick();
      RsByteD = 8'd3;
      #2;
      reset_n = 0;
      #1;
      n_chk++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL rst_rs_valid got=%b want=0", ValidE); end
      n_chk++; if ({ShOpE, ShCarryE} !== 33'h0) begin n_fail++; $display("FAIL rst_rs_out got=%h want=0", {ShOpE, ShCarryE}); end
      n_chk++; if (dut.state !== S_RUN) begin n_fail++; $display("FAIL rst_rs_state got=%0d want=%0d", dut.state, S_RUN); end
      n_chk++; if (StallReqD !== 1'b0) begin n_fail++; $display("FAIL rst_rs_stallreq got=%b want=0", StallReqD); end
      idle();
      @(negedge clk);
      reset_n = 1;
      drive_imm(32'h00000F0F, 1'b0, 1'b1);
      tick();
      idle();
      n_chk++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL rst_after_valid got=%b want=1", ValidE); end
      got = {ShOpE, ShCarryE};
      e = sb.pop_front();
      n_chk++; if (got !== e) begin n_fail++; $display("FAIL rst_after got=%h want=%h", got, e); end
   endtask

   initial begin
      test_reset();
      test_imm();
      test_imm_shift();
      test_reg_shift();
      test_stall();
      test_back_to_back();
      test_reset_mid_rs();
      n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
